entity_compositor: RTL and testbench
====================================

ENTITY_COMPOSITOR -- requirements
Module: entity_compositor

Interface
REQ-001 SHALL have parameter NUM_ENTITIES, default 9, number of entity channels (1..16).
REQ-002 SHALL have parameter COUNT_W, default 10, width of counter_H/counter_V.
REQ-003 SHALL have parameter H_ACTIVE, default 640, and V_ACTIVE, default 480, active-area size in pixels.
REQ-004 SHALL have parameter SCALE_SHIFT, default 2, log2 of the sprite-pixel-to-screen-pixel scale (8x8 sprite -> 32x32 tile).
REQ-005 SHALL have ports clk (in, 1, clock) and reset (in, 1, reset); one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: frame_start in 1 (shadow-to-active swap pulse); wr_valid in 1; wr_ready out 1; wr_index in clog2(NUM_ENTITIES); wr_data in 14 ([13:10] ID, [9:8] orientation, [7:0] tile {row[3:0],col[3:0]}); wr_error out 1 (out-of-range index pulse).
REQ-007 SHALL have ports counter_H in COUNT_W, counter_V in COUNT_W, colour out 1.

Function
REQ-008 SHALL hold two entity tables, shadow (written) and active (displayed), NUM_ENTITIES x 14 bits each.
REQ-009 SHALL accept a write when wr_valid && wr_ready at a rising edge; data lands in shadow[wr_index] that edge.
REQ-010 wr_ready SHALL be 1 every cycle except cycles where frame_start is 1.
REQ-011 wr_index >= NUM_ENTITIES SHALL complete the handshake, leave tables unchanged, and pulse wr_error for exactly one cycle the next cycle.
REQ-012 frame_start=1 SHALL copy the whole shadow table to active at that edge; a write held during that cycle SHALL be accepted the following cycle and not appear in active until the next frame_start.
REQ-013 Entity ID 4'hF SHALL mean unused; that channel never matches.
REQ-014 Tile coords SHALL be col = counter_H >> (3+SCALE_SHIFT), row = counter_V >> (3+SCALE_SHIFT); col or row >= 16 SHALL match nothing.
REQ-015 A channel SHALL match when its location equals {row[3:0],col[3:0]}; among matches the lowest channel index SHALL win.
REQ-016 Sprite pixel (r,c) SHALL be ((counter_V>>SCALE_SHIFT)[2:0], (counter_H>>SCALE_SHIFT)[2:0]), transformed per REQ-024, and looked up as sprite_rom[ID][r][c].
REQ-017 colour SHALL be 0 when no match, or counter_H >= H_ACTIVE, or counter_V >= V_ACTIVE; else the ROM bit of the winning entity.
REQ-018 Pixel path SHALL be a 3-stage pipeline: colour at edge N+3 reflects counters sampled at edge N+1; latency fixed, independent of NUM_ENTITIES.
REQ-019 Pipeline SHALL read the active table only; a swap mid-line affects pixels sampled after the swap edge.

Reset
REQ-020 On reset all shadow and active entries SHALL become {4'hF,2'b00,8'h00}.
REQ-021 On reset all pipeline registers SHALL clear; colour=0, wr_error=0, wr_ready=1 the cycle after reset deasserts.
REQ-022 reset SHALL override frame_start and any in-flight write in the same cycle.

Configuration
REQ-023 Macro ENTITY_ROTATE_EN SHALL select orientation handling.
REQ-024 With ENTITY_ROTATE_EN defined: orientation 00 -> (r,c); 01 -> (7-c,r); 10 -> (7-r,7-c); 11 -> (c,7-r). Without it: orientation bits stored but ignored, always (r,c).

Structure
REQ-025 Shared package stt8_gfx_pkg SHALL hold entity field widths/offsets, ID_UNUSED=4'hF, SPRITE_DIM=8, and the entity record typedef.
REQ-026 Sprite bitmap lookup SHALL be sub-module sprite_rom (16 IDs x 8x8, registered read, one pipeline stage).

Verification
REQ-027 Reset then scan full frame -> colour=0 everywhere; wr_ready=1.
REQ-028 Write ch0={ID1,00,8'h23}, frame_start, scan (H=96..127,V=64..95) -> colour equals sprite_rom[1] scaled 4x, 3-cycle latency; no output before frame_start.
REQ-029 ch2 and ch5 both at 8'h00 with IDs 2 and 3 -> tile 0 shows ID 2; set ch2 ID=4'hF and swap -> tile 0 shows ID 3.
REQ-030 wr_valid held with wr_index=2 across frame_start -> wr_ready=0 that cycle, accepted next cycle, visible only after second frame_start; wr_index=NUM_ENTITIES -> wr_error one-cycle pulse, tables unchanged.
REQ-031 Entity at 8'h0F (col 15, H=480..511) and probe H=640, V=10 -> sprite visible at col 15, colour=0 at H>=640.
REQ-032 Asymmetric sprite with orientation 01 -> rotated 90 deg with ENTITY_ROTATE_EN, unrotated without.

Source files
------------

// File: rtl/stt8_gfx_pkg.sv
// Shared STT8 graphics definitions: the entity record layout, the orientation
// encoding and the sprite geometry used by the compositor and its sprite ROM.
package stt8_gfx_pkg;

  localparam int unsigned ID_W       = 4;
  localparam int unsigned ORIENT_W   = 2;
  localparam int unsigned LOC_W      = 8;
  localparam int unsigned ENT_W      = ID_W + ORIENT_W + LOC_W;
  localparam int unsigned LOC_LSB    = 0;
  localparam int unsigned ORIENT_LSB = LOC_LSB + LOC_W;
  localparam int unsigned ID_LSB     = ORIENT_LSB + ORIENT_W;

  localparam logic [ID_W-1:0] ID_UNUSED = 4'hF;
  localparam int unsigned SPRITE_DIM  = 8;
  localparam int unsigned SPRITE_LOG2 = 3;
  localparam int unsigned GRID_DIM    = 16;

  typedef enum logic [ORIENT_W-1:0] {
    ORIENT_0   = 2'b00,
    ORIENT_90  = 2'b01,
    ORIENT_180 = 2'b10,
    ORIENT_270 = 2'b11
  } orient_e;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    orient_e          orient;
    logic [LOC_W-1:0] loc;
  } entity_t;

  localparam entity_t ENTITY_RESET = '{id: ID_UNUSED, orient: ORIENT_0, loc: '0};

  // Maps an on-screen sprite pixel to the bitmap pixel to fetch; result is {row, col}.
  function automatic logic [5:0] orient_pixel(input orient_e o, input logic [2:0] r,
                                              input logic [2:0] c);
    logic [5:0] rc;
    case (o)
      ORIENT_90:  rc = {3'd7 - c, r};
      ORIENT_180: rc = {3'd7 - r, 3'd7 - c};
      ORIENT_270: rc = {c, 3'd7 - r};
      default:    rc = {r, c};
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite bitmap store: 16 IDs of 8x8 one-bit pixels, pixel (r,c) at bit r*8+c,
// read through one registered stage.
module sprite_rom
  import stt8_gfx_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [ID_W-1:0] id_i,
  input  logic [2:0]      row_i,
  input  logic [2:0]      col_i,
  output logic            bit_o
);

  function automatic logic [63:0] sprite_bitmap(input logic [ID_W-1:0] id);
    logic [63:0] bm;
    case (id)
      4'h0: bm = 64'h8142_2418_1824_4281;
      4'h1: bm = 64'h0101_0101_1F01_01FF;
      4'h2: bm = 64'hFF81_8181_8181_81FF;
      4'h3: bm = 64'h0F0F_0F0F_0000_0000;
      4'h4: bm = 64'h0102_0408_1020_4080;
      4'h5: bm = 64'h3C42_8181_8181_423C;
      4'h6: bm = 64'hAA55_AA55_AA55_AA55;
      4'h7: bm = 64'hFFFF_0000_0000_0000;
      4'h8: bm = 64'h0303_0303_0303_0303;
      4'h9: bm = 64'h1824_4281_81FF_8181;
      4'hA: bm = 64'h7E02_0202_7E40_407E;
      4'hB: bm = 64'h00FF_00FF_00FF_00FF;
      4'hC: bm = 64'h8080_8080_80FF_FFFF;
      4'hD: bm = 64'h1357_9BDF_0246_8ACE;
      4'hE: bm = 64'h0F1E_3C78_F0E1_C387;
      default: bm = '0;
    endcase
    return bm;
  endfunction

  logic [63:0] bitmap;
  logic        bit_d, bit_q;

  always_comb begin
    bitmap = sprite_bitmap(id_i);
    bit_d  = bitmap[{row_i, col_i}];
  end

  always_ff @(posedge clk) begin
    if (reset) bit_q <= 1'b0;
    else       bit_q <= bit_d;
  end

  assign bit_o = bit_q;

endmodule

// File: rtl/entity_compositor.sv
// Tile-based sprite compositor with double-buffered entity table and a fixed
// 3-stage pixel pipeline. Define ENTITY_ROTATE_EN to honour entity orientation.
module entity_compositor
  import stt8_gfx_pkg::*;
#(
  parameter int unsigned NUM_ENTITIES = 9,
  parameter int unsigned COUNT_W      = 10,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned SCALE_SHIFT  = 2,
  localparam int unsigned IDX_W = (NUM_ENTITIES > 1) ? $clog2(NUM_ENTITIES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [ENT_W-1:0]   wr_data,
  output logic               wr_error,
  input  logic [COUNT_W-1:0] counter_H,
  input  logic [COUNT_W-1:0] counter_V,
  output logic               colour
);

  entity_t shadow_q [NUM_ENTITIES];
  entity_t shadow_d [NUM_ENTITIES];
  entity_t active_q [NUM_ENTITIES];
  entity_t active_d [NUM_ENTITIES];
  logic    wr_error_q, wr_error_d;
  logic    accept;

  logic [COUNT_W-1:0] tile_col, tile_row;
  logic [2:0]         sub_col, sub_row;
  logic               on_grid, on_screen, hit;
  logic [ID_W-1:0]    win_id;
`ifdef ENTITY_ROTATE_EN
  orient_e            win_orient;
`endif

  logic            hit1_q, hit1_d;
  logic [ID_W-1:0] id1_q, id1_d;
  logic [2:0]      prow1_q, prow1_d, pcol1_q, pcol1_d;
  logic            hit2_q, hit2_d;
  logic            colour_q, colour_d;
  logic            rom_bit;

  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    accept     = wr_valid && !frame_start;
    wr_error_d = accept && (32'(wr_index) >= NUM_ENTITIES);
    if (frame_start) active_d = shadow_q;
    for (int unsigned i = 0; i < NUM_ENTITIES; i++) begin
      if (accept && (32'(wr_index) == i)) shadow_d[i] = entity_t'(wr_data);
    end
  end

  // Stage 1 matches against the active table as it stood before this edge,
  // so a swap only affects pixels sampled on later edges.
  always_comb begin
    tile_col  = counter_H >> (SPRITE_LOG2 + SCALE_SHIFT);
    tile_row  = counter_V >> (SPRITE_LOG2 + SCALE_SHIFT);
    sub_col   = 3'(counter_H >> SCALE_SHIFT);
    sub_row   = 3'(counter_V >> SCALE_SHIFT);
    on_grid   = (32'(tile_col) < GRID_DIM) && (32'(tile_row) < GRID_DIM);
    on_screen = (32'(counter_H) < H_ACTIVE) && (32'(counter_V) < V_ACTIVE);
    hit       = 1'b0;
    win_id    = ID_UNUSED;
`ifdef ENTITY_ROTATE_EN
    win_orient = ORIENT_0;
`endif
    for (int unsigned i = 0; i < NUM_ENTITIES; i++) begin
      if (!hit && active_q[i].id != ID_UNUSED &&
          active_q[i].loc == {tile_row[3:0], tile_col[3:0]}) begin
        hit    = 1'b1;
        win_id = active_q[i].id;
`ifdef ENTITY_ROTATE_EN
        win_orient = active_q[i].orient;
`endif
      end
    end
    hit1_d = hit && on_grid && on_screen;
    id1_d  = win_id;
`ifdef ENTITY_ROTATE_EN
    {prow1_d, pcol1_d} = orient_pixel(win_orient, sub_row, sub_col);
`else
    {prow1_d, pcol1_d} = {sub_row, sub_col};
`endif
    hit2_d   = hit1_q;
    colour_d = hit2_q && rom_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ENTITIES; i++) begin
        shadow_q[i] <= ENTITY_RESET;
        active_q[i] <= ENTITY_RESET;
      end
      wr_error_q <= 1'b0;
      hit1_q     <= 1'b0;
      id1_q      <= '0;
      prow1_q    <= '0;
      pcol1_q    <= '0;
      hit2_q     <= 1'b0;
      colour_q   <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      wr_error_q <= wr_error_d;
      hit1_q     <= hit1_d;
      id1_q      <= id1_d;
      prow1_q    <= prow1_d;
      pcol1_q    <= pcol1_d;
      hit2_q     <= hit2_d;
      colour_q   <= colour_d;
    end
  end

  sprite_rom u_sprite_rom (
    .clk   (clk),
    .reset (reset),
    .id_i  (id1_q),
    .row_i (prow1_q),
    .col_i (pcol1_q),
    .bit_o (rom_bit)
  );

  assign wr_ready = !frame_start;
  assign wr_error = wr_error_q;
  assign colour   = colour_q;

endmodule

// File: tb/tb_entity_compositor.sv
// Randomized self-checking bench for entity_compositor against a frame-level
// model of the entity tables, tile geometry and sprite bitmaps.
module tb_entity_compositor;

  localparam int unsigned N = 9;

  logic        clk = 1'b0;
  logic        reset, frame_start, wr_valid, wr_ready, wr_error, colour;
  logic [3:0]  wr_index;
  logic [13:0] wr_data;
  logic [9:0]  counter_H, counter_V;

  entity_compositor #(
    .NUM_ENTITIES(N),
    .COUNT_W     (10),
    .H_ACTIVE    (640),
    .V_ACTIVE    (480),
    .SCALE_SHIFT (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_index   (wr_index),
    .wr_data    (wr_data),
    .wr_error   (wr_error),
    .counter_H  (counter_H),
    .counter_V  (counter_V),
    .colour     (colour)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  string       phase = "init";

  logic [63:0] rom_m    [16];
  logic [13:0] shadow_m [N];
  logic [13:0] active_m [N];
  logic        exp_q    [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, phase, got, exp);
    end
  endtask

  // Screen pixel -> colour, straight from the frame geometry: 32x32 tiles, 4x4 blocks.
  function automatic logic model_pixel(input int unsigned h, input int unsigned v);
    int unsigned col = h / 32;
    int unsigned row = v / 32;
    int unsigned r   = (v / 4) % 8;
    int unsigned c   = (h / 4) % 8;
    int unsigned pr, pc;
    if (h >= 640 || v >= 480 || col >= 16 || row >= 16) return 1'b0;
    for (int i = 0; i < N; i++) begin
      if (active_m[i][13:10] != 4'hF && active_m[i][7:0] == 8'(row * 16 + col)) begin
        pr = r;
        pc = c;
`ifdef ENTITY_ROTATE_EN
        case (active_m[i][9:8])
          2'd1: begin pr = 7 - c; pc = r;     end
          2'd2: begin pr = 7 - r; pc = 7 - c; end
          2'd3: begin pr = c;     pc = 7 - r; end
          default: ;
        endcase
`endif
        return rom_m[active_m[i][13:10]][pr * 8 + pc];
      end
    end
    return 1'b0;
  endfunction

  task automatic step(input int unsigned h, input int unsigned v, input logic fs,
                      input logic vld, input logic [3:0] idx, input logic [13:0] data);
    logic err_exp;
    counter_H   = 10'(h);
    counter_V   = 10'(v);
    frame_start = fs;
    wr_valid    = vld;
    wr_index    = idx;
    wr_data     = data;
    #1;
    check("wr_ready", {31'b0, wr_ready}, {31'b0, !fs});
    exp_q.push_back(model_pixel(h, v));
    err_exp = 1'b0;
    if (fs) active_m = shadow_m;
    else if (vld) begin
      if (idx < N) shadow_m[idx] = data;
      else         err_exp = 1'b1;
    end
    @(posedge clk);
    #1;
    check("wr_error", {31'b0, wr_error}, {31'b0, err_exp});
    if (exp_q.size() >= 3) check("colour", {31'b0, colour}, {31'b0, exp_q.pop_front()});
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned h, input int unsigned v);
    step(h, v, 1'b0, 1'b0, 4'd0, 14'd0);
  endtask

  task automatic write(input logic [3:0] idx, input logic [13:0] data);
    step(0, 0, 1'b0, 1'b1, idx, data);
  endtask

  task automatic swap();
    step(0, 0, 1'b1, 1'b0, 4'd0, 14'd0);
  endtask

  task automatic scan(input int unsigned h0, input int unsigned h1, input int unsigned v0,
                      input int unsigned v1, input int unsigned stride);
    for (int unsigned v = v0; v <= v1; v += stride)
      for (int unsigned h = h0; h <= h1; h += stride)
        idle(h, v);
  endtask

  // Writes and a swap are presented during reset; none may survive it.
  task automatic do_reset();
    reset = 1'b1; frame_start = 1'b1; wr_valid = 1'b1; wr_index = 4'd0;
    wr_data = 14'h0400; counter_H = '0; counter_V = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; frame_start = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      shadow_m[i] = 14'h3C00;
      active_m[i] = 14'h3C00;
    end
    exp_q.delete();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    #1;
    check("rst_colour", {31'b0, colour}, 32'd0);
    check("rst_wr_error", {31'b0, wr_error}, 32'd0);
    check("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rom_m = '{64'h8142_2418_1824_4281, 64'h0101_0101_1F01_01FF, 64'hFF81_8181_8181_81FF,
              64'h0F0F_0F0F_0000_0000, 64'h0102_0408_1020_4080, 64'h3C42_8181_8181_423C,
              64'hAA55_AA55_AA55_AA55, 64'hFFFF_0000_0000_0000, 64'h0303_0303_0303_0303,
              64'h1824_4281_81FF_8181, 64'h7E02_0202_7E40_407E, 64'h00FF_00FF_00FF_00FF,
              64'h8080_8080_80FF_FFFF, 64'h1357_9BDF_0246_8ACE, 64'h0F1E_3C78_F0E1_C387,
              64'h0000_0000_0000_0000};
    reset = 1'b1; frame_start = 1'b0; wr_valid = 1'b0; wr_index = '0; wr_data = '0;
    counter_H = '0; counter_V = '0;
    @(negedge clk);
    do_reset();

    phase = "blank";
    scan(0, 31, 0, 31, 2);
    repeat (1500) idle($urandom_range(0, 1023), $urandom_range(0, 1023));

    phase = "single";
    write(4'd0, 14'h0423);
    scan(96, 127, 64, 95, 1);
    swap();
    scan(96, 127, 64, 95, 1);

    phase = "priority";
    write(4'd2, 14'h0800);
    write(4'd5, 14'h0C00);
    swap();
    scan(0, 31, 0, 31, 1);
    write(4'd2, 14'h3C00);
    swap();
    scan(0, 31, 0, 31, 1);

    phase = "held_write";
    step(0, 0, 1'b1, 1'b1, 4'd2, 14'h1011);
    step(0, 0, 1'b0, 1'b1, 4'd2, 14'h1011);
    scan(32, 63, 32, 63, 2);
    swap();
    scan(32, 63, 32, 63, 2);

    phase = "bad_index";
    write(4'd9, 14'h0000);
    write(4'd15, 14'h0022);
    idle(0, 0);
    swap();
    scan(0, 31, 0, 31, 2);
    scan(64, 95, 64, 95, 2);
    scan(32, 63, 32, 63, 4);

    phase = "edge_col";
    write(4'd7, 14'h140F);
    swap();
    scan(480, 511, 0, 31, 1);
    idle(640, 10);
    for (int unsigned h = 500; h < 720; h += 3) idle(h, 10);
    idle(639, 10);
    idle(10, 480);

    phase = "orient";
    write(4'd1, 14'h0545);
    swap();
    scan(160, 191, 128, 159, 1);

    phase = "random";
    repeat (3000) begin
      logic        fs, vld;
      logic [3:0]  idx;
      logic [13:0] data;
      fs   = ($urandom_range(0, 15) == 0);
      vld  = ($urandom_range(0, 3) == 0);
      idx  = 4'($urandom_range(0, 15));
      data = {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0)
        step($urandom_range(0, 1023), $urandom_range(0, 1023), fs, vld, idx, data);
      else
        step($urandom_range(0, 127), $urandom_range(0, 127), fs, vld, idx, data);
    end

    phase = "drain";
    idle(0, 0);
    idle(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
